// File: rtl/partial_fm_accumulate.sv
// Sums three per-kernel partial feature maps plus a channel bias, one element per clock,
// through a saturating Q1.15 adder with optional ReLU. A rising edge of resting starts a pass.
module partial_fm_accumulate #(
    parameter  int ip_size     = 6,
    parameter  int kernel_size = 3,
    localparam int op_size     = ip_size - kernel_size + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [16*op_size*op_size-1:0]   IK1,
    input  logic [16*op_size*op_size-1:0]   IK2,
    input  logic [16*op_size*op_size-1:0]   IK3,
    input  logic [15:0]                     bias,
    input  logic                            relu_en,
    input  logic                            resting,
    output logic [16*op_size*op_size-1:0]   FM,
    output logic                            busy,
    output logic                            done,
    output logic                            sat_flag
);

    localparam int n_elem = op_size * op_size;
    localparam int idx_w  = (n_elem > 1) ? $clog2(n_elem) : 1;
    localparam int vec_w  = 16 * n_elem;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, next_state;
    logic               resting_q;
    logic               start;
    logic [idx_w-1:0]   idx;
    logic               last;
    logic [vec_w-1:0]   fm_q;

    logic [vec_w-1:0]   ik1_r, ik2_r, ik3_r;
    logic [15:0]        bias_r;
    logic               relu_r;

    logic [15:0]        e1, e2, e3;
    logic [17:0]        sum;
    logic [15:0]        result;
    logic               sat;

    assign start = resting & ~resting_q;
    assign last  = (idx == idx_w'(n_elem - 1));

    // NOTE: every variable written in an always_comb gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCUM;
            ACCUM:   if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // 18 bits holds the sum of four Q1.15 values without wrapping.
    always_comb begin
        e1     = ik1_r[16*idx +: 16];
        e2     = ik2_r[16*idx +: 16];
        e3     = ik3_r[16*idx +: 16];
        sum    = {{2{e1[15]}}, e1} + {{2{e2[15]}}, e2} + {{2{e3[15]}}, e3} + {{2{bias_r[15]}}, bias_r};
        result = sum[15:0];
        sat    = 1'b0;
        if (!sum[17] && (sum[16] || sum[15])) begin
            result = 16'h7FFF;
            sat    = 1'b1;
        end else if (sum[17] && !(sum[16] && sum[15])) begin
            result = 16'h8000;
            sat    = 1'b1;
        end
        if (relu_r && result[15]) result = 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            resting_q <= 1'b0;
            idx       <= '0;
            fm_q      <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state     <= next_state;
            resting_q <= resting;
            if (state == IDLE && start) begin
                idx      <= '0;
                sat_flag <= 1'b0;
            end else if (state == ACCUM) begin
                fm_q[16*idx +: 16] <= result;
                if (sat) sat_flag <= 1'b1;
                idx <= idx + 1'b1;
            end
        end
    end

    // NOTE: the snapshot registers carry no reset; they are always loaded on start before
    // anything reads them, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            ik1_r  <= IK1;
            ik2_r  <= IK2;
            ik3_r  <= IK3;
            bias_r <= bias;
            relu_r <= relu_en;
        end
    end

    assign FM   = fm_q;
    assign busy = (state == ACCUM);
    assign done = (state == DONE);

endmodule

// File: doc/partial_fm_accumulate.md
Name: partial_fm_accumulate

Overview:
Stage directly downstream of the partial feature-map producer. Sums the three per-kernel partial feature maps (IK1, IK2, IK3) element by element, adds a channel bias, and optionally applies ReLU. The result is the final op_size x op_size output feature map. Processing is serial, one element per clock, through a single saturating Q1.15 adder path. The upstream `resting` signal starts a pass.

Parameters:
ip_size, 6, input image side length; must match the upstream stage.
kernel_size, 3, kernel side length; must match the upstream stage.
op_size, ip_size-kernel_size+1 (4), output feature-map side length; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous active-low reset; asserted when 0.
IK1  in  16*op_size*op_size  partial FM, kernel 1, flattened row-major, Q1.15 signed; element i at [16*(i+1)-1 -: 16].
IK2  in  16*op_size*op_size  partial FM, kernel 2, same format.
IK3  in  16*op_size*op_size  partial FM, kernel 3, same format.
bias  in  16  channel bias, Q1.15 signed.
relu_en  in  1  1 = clamp negative results to 0.
resting  in  1  upstream completion flag; a rising edge starts one pass.
FM  out  16*op_size*op_size  accumulated feature map, same flattening as IK1.
busy  out  1  high while a pass is in progress.
done  out  1  one-cycle pulse when FM is complete.
sat_flag  out  1  sticky per pass; set if any element saturated.

Behaviour:
- Reset (rst=0, async): state=IDLE; FM=0; busy=0; done=0; sat_flag=0; index=0; resting edge register=0. Reset mid-pass aborts the pass; no done pulse is emitted afterwards.
- Start detection: resting is registered one cycle; start = resting & ~resting_q.
  - A level held high never retriggers.
  - A start while busy=1 is ignored.
- On start in IDLE, the following are snapshotted into internal registers: IK1, IK2, IK3, bias, relu_en. Later input changes do not affect the pass. Also on start: sat_flag cleared, index=0, busy=1, state goes to ACCUM.
- ACCUM, one element per cycle at index i (0 .. op_size*op_size-1):
  - s = sext18(IK1[i]) + sext18(IK2[i]) + sext18(IK3[i]) + sext18(bias), computed in 18-bit signed.
  - If s > 32767, result = 0x7FFF and sat_flag is set. If s < -32768, result = 0x8000 and sat_flag is set. Otherwise result = s[15:0].
  - If relu_en and result is negative, result = 0. A ReLU clamp alone does not set sat_flag.
  - FM[i] is written with the result; index increments.
  - Elements not yet processed hold their previous-pass values.
- After the last element is written: state goes to DONE.
- DONE (one cycle): done=1, busy=0, then state returns to IDLE.
- Latency: done asserts op_size*op_size+1 cycles after the cycle in which start is sampled. With the default, that is 17 cycles.
- FM holds its value until the next pass overwrites it element by element.
- States: IDLE -> ACCUM -> DONE -> IDLE. Illegal state encodings recover to IDLE.
- A new rising edge of resting arriving in the DONE cycle is accepted only if start is sampled in IDLE. An edge that falls during ACCUM or DONE is lost; upstream guarantees spacing.

Test Plan:
- All IK1=4096, IK2=2048, IK3=1024, bias=0, relu_en=0; pulse resting -> every FM element = 7168. done pulses exactly 17 cycles after start is sampled. sat_flag=0, busy high for 16 cycles.
- All IK1=IK2=IK3=16384, bias=0 -> every FM element = 32767, sat_flag=1. Then IK1=IK2=IK3=bias=-16384 (0xC000) -> every element = 0x8000 (-32768), sat_flag=1.
- IK1=0xC000, IK2=IK3=0, bias=0x1000: with relu_en=0 -> every element = 0xD000, sat_flag=0. With relu_en=1 -> every element = 0.
- Hold resting high 50 cycles after a pass -> exactly one done pulse. Toggle IK1 during ACCUM -> FM reflects the snapshot values only.
- Drive rst=0 asynchronously at element 7 of a pass -> FM=0, busy=0 immediately, no done pulse. After release, a fresh resting edge -> correct full pass.
- Second resting edge issued while busy -> ignored: a single done pulse, FM from the first snapshot.
